crc_checker: RTL and testbench

- Serial CRC receive-side checker, the counterpart of the transmit-side per-bit CRC generator.
- Accepts a frame one bit per qualified cycle: LEN data bits followed by the W-bit CRC field, with W = 5 (CRC-5) or 8 (CRC-8).
- Runs every bit through the same per-bit remainder update the generator uses, then reports pass/fail.
- Sits between the deserialiser and the packet handler in the receive path.

---
 rtl/crc_checker_pkg.sv | 28 ++
 rtl/crc_checker_if.sv | 27 ++
 rtl/crc_checker_step.sv | 34 +++
 rtl/crc_checker.sv | 150 +++++++++++++++
 tb/tb_crc_checker.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/crc_checker_pkg.sv
// crc_checker_pkg: shared FSM encoding, CRC widths and mode encoding
// for the serial CRC receive checker and its per-bit step logic.
package crc_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int CRC5_W = 5;
   localparam int CRC8_W = 8;
   localparam int REM_W  = 9;

   localparam logic SEL_CRC5 = 1'b1;
   localparam logic SEL_CRC8 = 1'b0;

   function automatic int unsigned crc_width(input logic sel);
      return (sel == SEL_CRC5) ? CRC5_W : CRC8_W;
   endfunction

   // CRC-5 keeps six live remainder bits, CRC-8 all nine.
   function automatic logic [REM_W-1:0] rem_mask(input logic sel);
      return (sel == SEL_CRC5) ? 9'h03F : 9'h1FF;
   endfunction

endpackage

// File: rtl/crc_checker_if.sv
// crc_checker_if: frame control, serial bit input and result bundle.
// master drives start/sel/len/bit_valid/bit_in; slave returns results.
interface crc_checker_if #(
   parameter int LEN_W = 11
);
   logic             start;
   logic             sel;
   logic [LEN_W-1:0] len;
   logic             bit_valid;
   logic             bit_in;
   logic             busy;
   logic             done;
   logic             crc_ok;
   logic             crc_err;
   logic [8:0]       rem_out;
   logic [7:0]       err_cnt;

   modport master (
      output start, sel, len, bit_valid, bit_in,
      input  busy, done, crc_ok, crc_err, rem_out, err_cnt
   );

   modport slave (
      input  start, sel, len, bit_valid, bit_in,
      output busy, done, crc_ok, crc_err, rem_out, err_cnt
   );
endinterface

// File: rtl/crc_checker_step.sv
// crc_step: combinational per-bit remainder update shared with the
// transmit generator. Ports: sel, bit_in, rem_in[8:0] -> rem_out[8:0].
module crc_step
   import crc_checker_pkg::*;
(
   input  logic             sel,
   input  logic             bit_in,
   input  logic [REM_W-1:0] rem_in,
   output logic [REM_W-1:0] rem_out
);

   always_comb begin
      rem_out = '0;
      if (sel == SEL_CRC5) begin
         rem_out[0] = bit_in;
         rem_out[1] = rem_in[0] ^ rem_in[5];
         rem_out[2] = rem_in[1] ^ rem_in[5];
         rem_out[3] = rem_in[2];
         rem_out[4] = rem_in[3] ^ rem_in[5];
         rem_out[5] = rem_in[4];
      end else begin
         rem_out[0] = bit_in;
         rem_out[1] = rem_in[0] ^ rem_in[8];
         rem_out[2] = rem_in[1];
         rem_out[3] = rem_in[2];
         rem_out[4] = rem_in[3];
         rem_out[5] = rem_in[4] ^ rem_in[8];
         rem_out[6] = rem_in[5] ^ rem_in[8];
         rem_out[7] = rem_in[6];
         rem_out[8] = rem_in[7];
      end
   end

endmodule

// File: rtl/crc_checker.sv
// crc_checker: serial CRC-5/CRC-8 receive checker (LEN data bits then CRC).
// Ports: clk, rst_n (async low), bus (crc_checker_if.slave).
// Optional: CRC_CHK_ERRCNT_EN enables the saturating bad-frame counter.
module crc_checker
   import crc_checker_pkg::*;
#(
   parameter int LEN_W = 11
) (
   input  logic clk,
   input  logic rst_n,
   crc_checker_if.slave bus
);

   state_e           state_q, state_d;
   logic             sel_q, sel_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] cnt_inc;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [REM_W-1:0] res_q, res_d;
   logic [REM_W-1:0] rem_nxt;
   logic             ok_q, ok_d;
   logic             err_q, err_d;
   logic             busy;
   logic             done;

   crc_step u_step (
      .sel     (sel_q),
      .bit_in  (bus.bit_in),
      .rem_in  (rem_q),
      .rem_out (rem_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         res_q   <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         res_q   <= res_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      res_d   = res_q;
      ok_d    = ok_q;
      err_d   = err_q;
      busy    = 1'b0;
      done    = 1'b0;
      cnt_inc = cnt_q + LEN_W'(1);

      unique case (state_q)
         ST_IDLE: ;
         ST_DATA: begin
            busy = 1'b1;
            if (bus.bit_valid) begin
               rem_d = rem_nxt;
               if (cnt_inc == len_q) begin
                  cnt_d   = '0;
                  state_d = ST_CHECK;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         ST_CHECK: begin
            busy = 1'b1;
            if (bus.bit_valid) begin
               rem_d = rem_nxt;
               if (cnt_inc == LEN_W'(crc_width(sel_q))) begin
                  // Results are captured here so they are valid
                  // alongside the done pulse.
                  cnt_d   = '0;
                  state_d = ST_DONE;
                  res_d   = rem_nxt & rem_mask(sel_q);
                  ok_d    = (res_d == '0);
                  err_d   = ~ok_d;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // start wins in every state; the bit offered in the same cycle
      // is dropped and an aborted frame never reaches DONE.
      if (bus.start) begin
         sel_d   = bus.sel;
         len_d   = bus.len;
         cnt_d   = '0;
         rem_d   = '0;
         res_d   = '0;
         ok_d    = 1'b0;
         err_d   = 1'b0;
         state_d = (bus.len == '0) ? ST_CHECK : ST_DATA;
      end
   end

   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.crc_ok  = ok_q;
   assign bus.crc_err = err_q;
   assign bus.rem_out = res_q;

`ifdef CRC_CHK_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (done && err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.err_cnt = err_cnt_q;
`else
   assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_crc_checker.sv
// tb_crc_checker: scoreboard bench for crc_checker with directed frames.
// Expected results are queued by stimulus and popped by a done monitor.
module tb_crc_checker;
   import crc_checker_pkg::*;

   typedef struct packed {
      logic       ok;
      logic       err;
      logic [8:0] rem;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   exp_errcnt = 0;

   always #5 clk = ~clk;

   crc_checker_if #(.LEN_W(11)) bus ();

   crc_checker #(.LEN_W(11)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   exp_t e;
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected none");
         end else begin
            e = q.pop_front();
            check("crc_ok", 32'(bus.crc_ok), 32'(e.ok));
            check("crc_err", 32'(bus.crc_err), 32'(e.err));
            check("rem_out", 32'(bus.rem_out), 32'(e.rem));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_result(input logic ok, input logic [8:0] rem);
      exp_t x;
      x.ok  = ok;
      x.err = ~ok;
      x.rem = rem;
      q.push_back(x);
      if (!ok && exp_errcnt < 255) exp_errcnt++;
   endtask

   task automatic check_errcnt(input string name);
`ifdef CRC_CHK_ERRCNT_EN
      check(name, 32'(bus.err_cnt), 32'(exp_errcnt));
`else
      check(name, 32'(bus.err_cnt), 32'd0);
`endif
   endtask

   task automatic start_frame(input logic s, input int l);
      bus.start = 1'b1;
      bus.sel   = s;
      bus.len   = 11'(l);
      tick();
      bus.start = 1'b0;
      bus.sel   = ~s;
      bus.len   = 11'h7FF;
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n,
                            input int gap);
      for (int i = 0; i < n; i++) begin
         if (i > 0) repeat (gap) tick();
         bus.bit_valid = 1'b1;
         bus.bit_in    = bits[i];
         tick();
         bus.bit_valid = 1'b0;
         bus.bit_in    = 1'b0;
      end
   endtask

   task automatic run_frame(input string name, input logic s, input int l,
                            input logic [31:0] bits, input int n,
                            input int gap, input logic ok,
                            input logic [8:0] rem);
      expect_result(ok, rem);
      start_frame(s, l);
      check({name, "_busy"}, 32'(bus.busy), 32'd1);
      send_bits(bits, n, gap);
      check({name, "_done_latency"}, 32'(bus.done), 32'd1);
      tick();
      check({name, "_idle"}, 32'(bus.busy | bus.done), 32'd0);
      check_errcnt({name, "_errcnt"});
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.sel       = 1'b0;
      bus.len       = '0;
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      #12;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_ok", 32'(bus.crc_ok), 32'd0);
      check("rst_err", 32'(bus.crc_err), 32'd0);
      check("rst_rem", 32'(bus.rem_out), 32'd0);
      check("rst_errcnt", 32'(bus.err_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      // Stray bits in IDLE must be ignored.
      send_bits(32'h3, 2, 0);
      tick();

      run_frame("c5_zero", SEL_CRC5, 11, 32'h0, 16, 0, 1'b1, 9'h000);
      run_frame("c5_bad", SEL_CRC5, 1, 32'h1, 6, 0, 1'b0, 9'h020);
      run_frame("c8_bad", SEL_CRC8, 1, 32'h1, 9, 0, 1'b0, 9'h100);
      run_frame("c8_gap", SEL_CRC8, 1, 32'h1, 9, 3, 1'b0, 9'h100);
      run_frame("c8_len0", SEL_CRC8, 0, 32'h0, 8, 0, 1'b1, 9'h000);
      run_frame("c5_fb", SEL_CRC5, 2, 32'h1, 7, 0, 1'b0, 9'h016);
      run_frame("c8_fb", SEL_CRC8, 2, 32'h1, 10, 1, 1'b0, 9'h062);

      // Abort a CRC-5 frame; the bit offered with start is dropped.
      start_frame(SEL_CRC5, 5);
      send_bits(32'h7, 3, 0);
      expect_result(1'b1, 9'h000);
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      start_frame(SEL_CRC8, 4);
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      send_bits(32'h0, 12, 0);
      check("abort_done", 32'(bus.done), 32'd1);
      tick();
      check_errcnt("abort_errcnt");

      // start during DONE: result still reported, cleared next cycle.
      expect_result(1'b1, 9'h000);
      start_frame(SEL_CRC5, 0);
      send_bits(32'h0, 5, 0);
      check("sdone_done", 32'(bus.done), 32'd1);
      expect_result(1'b1, 9'h000);
      bus.start = 1'b1;
      bus.sel   = SEL_CRC5;
      bus.len   = '0;
      tick();
      bus.start = 1'b0;
      check("sdone_clear", 32'(bus.crc_ok), 32'd0);
      check("sdone_busy", 32'(bus.busy), 32'd1);
      send_bits(32'h0, 5, 0);
      check("sdone_done2", 32'(bus.done), 32'd1);
      tick();

      // Reset in CHECK clears everything at once.
      start_frame(SEL_CRC8, 0);
      send_bits(32'h0, 3, 0);
      #2;
      rst_n = 1'b0;
      #1;
      exp_errcnt = 0;
      check("mrst_busy", 32'(bus.busy), 32'd0);
      check("mrst_done", 32'(bus.done), 32'd0);
      check("mrst_ok", 32'(bus.crc_ok | bus.crc_err), 32'd0);
      check("mrst_rem", 32'(bus.rem_out), 32'd0);
      check("mrst_errcnt", 32'(bus.err_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      send_bits(32'h1F, 5, 0);
      tick();

`ifdef CRC_CHK_ERRCNT_EN
      for (int i = 0; i < 260; i++) begin
         expect_result(1'b0, 9'h010);
         start_frame(SEL_CRC5, 0);
         send_bits(32'h1, 5, 0);
         tick();
      end
      check("sat_errcnt", 32'(bus.err_cnt), 32'd255);
`endif

      repeat (3) tick();
      check("queue_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
